// File: rtl/eth_pkg.sv
// Shared Ethernet path types: packet direction tags, word widths and the
// RX demultiplexer state encoding.
package eth_pkg;

  localparam int ETH_TAG_W  = 2;
  localparam int ETH_WORD_W = 81;

  typedef enum logic [1:0] {
    CQ = 2'd0,
    CC = 2'd1,
    RQ = 2'd2,
    RC = 2'd3
  } pktdir_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_FWD0 = 2'd1,
    RX_FWD1 = 2'd2,
    RX_DROP = 2'd3
  } rxdemux_state_t;

  // Requester-side traffic (RQ/RC) has no consumer on this path and is dropped.
  function automatic rxdemux_state_t rx_dest_state(input pktdir_t tag);
    case (tag)
      CQ:      return RX_FWD0;
      CC:      return RX_FWD1;
      default: return RX_DROP;
    endcase
  endfunction

endpackage

// File: rtl/eth_rxdemux_stats.sv
// Packet/drop statistics counters for eth_rxdemux, driven by per-destination
// end-of-packet strobes. Counters wrap at 2^32.
module eth_rxdemux_stats
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ev_pkt0,
  input  logic        ev_pkt1,
  input  logic        ev_drop,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1,
  output logic [31:0] drop_cnt
);

  logic [31:0] pkt_cnt0_r;
  logic [31:0] pkt_cnt1_r;
  logic [31:0] drop_cnt_r;

  // Event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0_r <= 32'd0;
      pkt_cnt1_r <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (ev_pkt0) pkt_cnt0_r <= pkt_cnt0_r + 32'd1;
      if (ev_pkt1) pkt_cnt1_r <= pkt_cnt1_r + 32'd1;
      if (ev_drop) drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_r;
  assign pkt_cnt1 = pkt_cnt1_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: rtl/eth_rxdemux.sv
// RX packet demultiplexer: steers whole tagged packets from one FWFT FIFO to
// FIFO0 (CQ), FIFO1 (CC) or drops them. Stats ports under ETH_RXDEMUX_STATS_EN.
module eth_rxdemux
  import eth_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ETH_TAG_W+ETH_WORD_W-1:0]   in_dout,
  input  logic                              in_empty,
  output logic                              in_rd_en,
  output logic [ETH_WORD_W-1:0]             out0_din,
  input  logic                              out0_full,
  output logic                              out0_wr_en,
  output logic [ETH_WORD_W-1:0]             out1_din,
  input  logic                              out1_full,
  output logic                              out1_wr_en
`ifdef ETH_RXDEMUX_STATS_EN
  ,
  output logic [31:0]                       pkt_cnt0,
  output logic [31:0]                       pkt_cnt1,
  output logic [31:0]                       drop_cnt
`endif
);

  rxdemux_state_t         state_r;
  logic                   rd_en_s;
  pktdir_t                tag_s;
  logic [ETH_WORD_W-1:0]  word_s;
  logic                   last_s;
  logic [ETH_WORD_W-1:0]  out0_din_r;
  logic [ETH_WORD_W-1:0]  out1_din_r;
  logic                   out0_wr_en_r;
  logic                   out1_wr_en_r;

  assign tag_s  = pktdir_t'(in_dout[ETH_TAG_W+ETH_WORD_W-1 -: ETH_TAG_W]);
  assign word_s = in_dout[ETH_WORD_W-1:0];
  assign last_s = in_dout[0];

  // Pop decision: only the targeted output's full flag gates the pop
  always_comb begin
    rd_en_s = 1'b0;
    case (state_r)
      RX_IDLE: rd_en_s = 1'b0;
      RX_FWD0: rd_en_s = !in_empty && !out0_full;
      RX_FWD1: rd_en_s = !in_empty && !out1_full;
      RX_DROP: rd_en_s = !in_empty;
      default: rd_en_s = 1'b0;
    endcase
  end

  // Packet FSM and registered write stage; tag is looked at only in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RX_IDLE;
      out0_din_r   <= {ETH_WORD_W{1'b0}};
      out1_din_r   <= {ETH_WORD_W{1'b0}};
      out0_wr_en_r <= 1'b0;
      out1_wr_en_r <= 1'b0;
    end else begin
      out0_wr_en_r <= 1'b0;
      out1_wr_en_r <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (!in_empty) state_r <= rx_dest_state(tag_s);
        end
        RX_FWD0: begin
          if (rd_en_s) begin
            out0_din_r   <= word_s;
            out0_wr_en_r <= 1'b1;
            if (last_s) state_r <= RX_IDLE;
          end
        end
        RX_FWD1: begin
          if (rd_en_s) begin
            out1_din_r   <= word_s;
            out1_wr_en_r <= 1'b1;
            if (last_s) state_r <= RX_IDLE;
          end
        end
        RX_DROP: begin
          if (rd_en_s && last_s) state_r <= RX_IDLE;
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign in_rd_en   = rd_en_s;
  assign out0_din   = out0_din_r;
  assign out1_din   = out1_din_r;
  assign out0_wr_en = out0_wr_en_r;
  assign out1_wr_en = out1_wr_en_r;

`ifdef ETH_RXDEMUX_STATS_EN
  logic ev_pkt0_s;
  logic ev_pkt1_s;
  logic ev_drop_s;

  assign ev_pkt0_s = out0_wr_en_r && out0_din_r[0];
  assign ev_pkt1_s = out1_wr_en_r && out1_din_r[0];
  assign ev_drop_s = (state_r == RX_DROP) && rd_en_s && last_s;

  eth_rxdemux_stats u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_pkt0  (ev_pkt0_s),
    .ev_pkt1  (ev_pkt1_s),
    .ev_drop  (ev_drop_s),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1),
    .drop_cnt (drop_cnt)
  );
`endif

endmodule
